// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the Ascon-128 AEAD control FSM.
// Holds the controller state encoding, the round-number landmarks of the
// p12 / p6 permutations and a width helper for the block index.
package ascon_ctrl_fsm_pkg;

  // Controller states. WAIT states sit between permutation phases and
  // wait for the next data block; the others run one round per cycle.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT       = 4'd1,
    AD_WAIT    = 4'd2,
    AD         = 4'd3,
    PT_WAIT    = 4'd4,
    PT         = 4'd5,
    FINAL_WAIT = 4'd6,
    FINAL      = 4'd7,
    DONE       = 4'd8
  } ctrl_state_t;

  // p12 runs rounds 0..11, p6 runs rounds 6..11; both end on round 11.
  localparam logic [3:0] ROUND_P12_START = 4'd0;
  localparam logic [3:0] ROUND_P6_START  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  // Width of the block index: enough to hold max(nb_ad, nb_pt).
  function automatic int blk_width(input int nb_ad, input int nb_pt);
    int m;
    m = (nb_ad > nb_pt) ? nb_ad : nb_pt;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round counter for the Ascon permutation.
// Loaded with the first round of a phase, then advanced once per
// permutation cycle. It stops at round 11 and never wraps, so a stray
// enable after the last round cannot produce an out-of-range round number.
module ascon_ctrl_fsm_round_counter
  import ascon_ctrl_fsm_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       last_o
);

  logic [3:0] count_q;

  // Counter register: load wins over increment; increment saturates at round 11.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_q <= 4'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != ROUND_LAST)) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == ROUND_LAST);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 AEAD control FSM.
// Sequences init p12 -> associated data p6 (per block) -> plaintext p6
// (per block, all but the last) -> final p12, one permutation round per
// cycle, and drives the datapath mode, round number, register enable,
// XOR enables and ciphertext/tag capture strobes.
// The last plaintext block is absorbed by the FINAL phase, so the PT phase
// only runs for blocks 0..NB_PT_BLOCKS-2.
//
// Optional feature: define ASCON_CTRL_ABORT_EN to add abort_i, which returns
// the controller to IDLE from any busy state on the next edge, with no
// done_o pulse. Without the macro every started operation runs to DONE.
//
// Block handshake: data_valid_i is a level that says "the next AD/PT/final
// block is present". It is looked at only in the *_WAIT states; the cycle it
// is seen high there, the matching permutation phase starts on the next edge.
// There is no ready: the WAIT state itself is the ready indication, and each
// WAIT state lasts at least one cycle even if data_valid_i is held high.
//
// All outputs are Moore decodes of state, round counter and block counter.
module ascon_ctrl_fsm
  import ascon_ctrl_fsm_pkg::*;
#(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic clock_i,
  input  logic resetb_i,
  input  logic start_i,
  input  logic data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic abort_i,
`endif
  output logic input_mode_o,
  output logic [3:0] round_o,
  output logic en_reg_state_o,
  output logic en_xor_data_begin_o,
  output logic en_xor_key_begin_o,
  output logic en_xor_key_end_o,
  output logic en_xor_lsb_end_o,
  output logic en_cipher_o,
  output logic en_tag_o,
  output logic [blk_width(NB_AD_BLOCKS, NB_PT_BLOCKS)-1:0] block_o,
  output logic busy_o,
  output logic done_o
);

  localparam int BLK_W = blk_width(NB_AD_BLOCKS, NB_PT_BLOCKS);

  // Index of the last AD block, and of the last block handled by PT (the
  // final PT block is absorbed by FINAL). PT_LAST is unused when
  // NB_PT_BLOCKS == 1 because PT is then never entered.
  localparam logic [BLK_W-1:0] AD_LAST = BLK_W'(NB_AD_BLOCKS - 1);
  localparam logic [BLK_W-1:0] PT_LAST =
    BLK_W'((NB_PT_BLOCKS >= 2) ? (NB_PT_BLOCKS - 2) : 0);

  ctrl_state_t       state_q;
  ctrl_state_t       state_nxt;
  logic [BLK_W-1:0]  block_q;
  logic [BLK_W-1:0]  block_nxt;

  logic              rc_load;
  logic [3:0]        rc_load_val;
  logic              rc_en;
  logic [3:0]        round_q;
  logic              round_last;

  logic              abort;

`ifdef ASCON_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  ascon_ctrl_fsm_round_counter u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load_i     (rc_load),
    .load_val_i (rc_load_val),
    .en_i       (rc_en),
    .count_o    (round_q),
    .last_o     (round_last)
  );

  // State and block-counter registers.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      block_q <= '0;
    end else begin
      state_q <= state_nxt;
      block_q <= block_nxt;
    end
  end

  // Next state, block counter update and round-counter control.
  always_comb begin
    state_nxt   = state_q;
    block_nxt   = block_q;
    rc_load     = 1'b0;
    rc_load_val = ROUND_P12_START;
    rc_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_nxt   = INIT;
          rc_load     = 1'b1;
          rc_load_val = ROUND_P12_START;
        end
      end

      INIT: begin
        rc_en = 1'b1;
        if (round_last) begin
          state_nxt = AD_WAIT;
          block_nxt = '0;
        end
      end

      AD_WAIT: begin
        if (data_valid_i) begin
          state_nxt   = AD;
          rc_load     = 1'b1;
          rc_load_val = ROUND_P6_START;
        end
      end

      AD: begin
        rc_en = 1'b1;
        if (round_last) begin
          if (block_q == AD_LAST) begin
            // With a single PT block there is nothing for PT to do.
            state_nxt = (NB_PT_BLOCKS == 1) ? FINAL_WAIT : PT_WAIT;
            block_nxt = '0;
          end else begin
            state_nxt = AD_WAIT;
            block_nxt = block_q + BLK_W'(1);
          end
        end
      end

      PT_WAIT: begin
        if (data_valid_i) begin
          state_nxt   = PT;
          rc_load     = 1'b1;
          rc_load_val = ROUND_P6_START;
        end
      end

      PT: begin
        rc_en = 1'b1;
        if (round_last) begin
          if (block_q == PT_LAST) begin
            state_nxt = FINAL_WAIT;
            block_nxt = '0;
          end else begin
            state_nxt = PT_WAIT;
            block_nxt = block_q + BLK_W'(1);
          end
        end
      end

      FINAL_WAIT: begin
        if (data_valid_i) begin
          state_nxt   = FINAL;
          rc_load     = 1'b1;
          rc_load_val = ROUND_P12_START;
        end
      end

      FINAL: begin
        rc_en = 1'b1;
        if (round_last) begin
          state_nxt = DONE;
          block_nxt = '0;
        end
      end

      DONE: begin
        // start_i is deliberately not looked at here.
        state_nxt   = IDLE;
        block_nxt   = '0;
        rc_load     = 1'b1;
        rc_load_val = ROUND_P12_START;
      end

      default: begin
        state_nxt   = IDLE;
        block_nxt   = '0;
        rc_load     = 1'b1;
        rc_load_val = ROUND_P12_START;
      end
    endcase

    // Abort overrides everything, including a pending data_valid_i.
    if (abort && (state_q != IDLE)) begin
      state_nxt   = IDLE;
      block_nxt   = '0;
      rc_load     = 1'b1;
      rc_load_val = ROUND_P12_START;
      rc_en       = 1'b0;
    end
  end

  // Moore output decode from state, round and block counters.
  always_comb begin
    input_mode_o        = 1'b0;
    round_o             = 4'd0;
    en_reg_state_o      = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    block_o             = block_q;
    busy_o              = (state_q != IDLE);
    done_o              = 1'b0;

    case (state_q)
      IDLE: begin
        block_o = '0;
      end

      INIT: begin
        round_o          = round_q;
        en_reg_state_o   = 1'b1;
        input_mode_o     = (round_q == ROUND_P12_START);
        en_xor_key_end_o = round_last;
      end

      AD: begin
        round_o             = round_q;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (round_q == ROUND_P6_START);
        en_xor_lsb_end_o    = round_last && (block_q == AD_LAST);
      end

      PT: begin
        round_o             = round_q;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (round_q == ROUND_P6_START);
        en_cipher_o         = (round_q == ROUND_P6_START);
      end

      FINAL: begin
        round_o             = round_q;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (round_q == ROUND_P12_START);
        en_xor_key_begin_o  = (round_q == ROUND_P12_START);
        en_cipher_o         = (round_q == ROUND_P12_START);
        en_xor_key_end_o    = round_last;
        en_tag_o            = round_last;
      end

      DONE: begin
        done_o = 1'b1;
      end

      default: begin
        // WAIT states: busy, block index visible, datapath idle.
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: a default instance (1 AD, 4 PT blocks) and a
// second instance with 2 AD blocks and 1 PT block. Expected per-cycle output
// vectors are built from the phase description and queued when an operation
// is started; each cycle the head is popped and compared with the DUT.
module tb_ascon_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1: defaults ----------------
  logic       rst1_n, start1, dv1;
  logic       im1, er1, xdb1, xkb1, xke1, xlsb1, ciph1, tag1, busy1, done1;
  logic [3:0] round1;
  logic [2:0] blk1;
`ifdef ASCON_CTRL_ABORT_EN
  logic       abort1;
`endif

  ascon_ctrl_fsm u_dut1 (
    .clock_i             (clk),
    .resetb_i            (rst1_n),
    .start_i             (start1),
    .data_valid_i        (dv1),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i             (abort1),
`endif
    .input_mode_o        (im1),
    .round_o             (round1),
    .en_reg_state_o      (er1),
    .en_xor_data_begin_o (xdb1),
    .en_xor_key_begin_o  (xkb1),
    .en_xor_key_end_o    (xke1),
    .en_xor_lsb_end_o    (xlsb1),
    .en_cipher_o         (ciph1),
    .en_tag_o            (tag1),
    .block_o             (blk1),
    .busy_o              (busy1),
    .done_o              (done1)
  );

  // ---------------- DUT 2: 2 AD blocks, 1 PT block ----------------
  logic       rst2_n, start2, dv2;
  logic       im2, er2, xdb2, xkb2, xke2, xlsb2, ciph2, tag2, busy2, done2;
  logic [3:0] round2;
  logic [1:0] blk2;
`ifdef ASCON_CTRL_ABORT_EN
  logic       abort2;
  assign abort2 = 1'b0;
`endif

  ascon_ctrl_fsm #(.NB_AD_BLOCKS(2), .NB_PT_BLOCKS(1)) u_dut2 (
    .clock_i             (clk),
    .resetb_i            (rst2_n),
    .start_i             (start2),
    .data_valid_i        (dv2),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i             (abort2),
`endif
    .input_mode_o        (im2),
    .round_o             (round2),
    .en_reg_state_o      (er2),
    .en_xor_data_begin_o (xdb2),
    .en_xor_key_begin_o  (xkb2),
    .en_xor_key_end_o    (xke2),
    .en_xor_lsb_end_o    (xlsb2),
    .en_cipher_o         (ciph2),
    .en_tag_o            (tag2),
    .block_o             (blk2),
    .busy_o              (busy2),
    .done_o              (done2)
  );

  // Output vector: [16]busy [15]done [14]input_mode [13:10]round [9]en_reg
  // [8]xor_data_begin [7]xor_key_begin [6]xor_key_end [5]xor_lsb_end
  // [4]cipher [3]tag [2:0]block
  localparam int W = 17;
  logic [W-1:0] obs1, obs2;
  assign obs1 = {busy1, done1, im1, round1, er1, xdb1, xkb1, xke1, xlsb1,
                 ciph1, tag1, blk1};
  assign obs2 = {busy2, done2, im2, round2, er2, xdb2, xkb2, xke2, xlsb2,
                 ciph2, tag2, 1'b0, blk2};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total  = 0;
  int passed = 0;

  // Per-run observations.
  int ciph_cnt, tag_cnt, im_cnt, lsb_cnt, done_cnt;
  int done_cyc, lsb_cyc, im_cyc;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [W-1:0] mk(input bit busy, input bit done,
      input bit im, input int round, input bit er, input bit xdb,
      input bit xkb, input bit xke, input bit xlsb, input bit ciph,
      input bit tag, input int blk);
    logic [3:0] r;
    logic [2:0] b;
    r = 4'(round);
    b = 3'(blk);
    return {busy, done, im, r, er, xdb, xkb, xke, xlsb, ciph, tag, b};
  endfunction

  // kind: 0 INIT, 1 AD, 2 PT, 3 FINAL
  task automatic push_phase(input int kind, input int blk, input bit last_ad);
    int rs;
    rs = (kind == 1 || kind == 2) ? 6 : 0;
    for (int r = rs; r <= 11; r++) begin
      exp_q.push_back(mk(1'b1, 1'b0,
        (kind == 0 && r == 0),
        r, 1'b1,
        ((kind == 1 || kind == 2) && r == 6) || (kind == 3 && r == 0),
        (kind == 3 && r == 0),
        ((kind == 0 || kind == 3) && r == 11),
        (kind == 1 && r == 11 && last_ad),
        (kind == 2 && r == 6) || (kind == 3 && r == 0),
        (kind == 3 && r == 11),
        blk));
    end
  endtask

  task automatic push_wait(input int blk, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, blk));
  endtask

  // Whole operation: one wait per block except the first PT wait.
  task automatic build_seq(input int nb_ad, input int nb_pt, input int pt_wait0);
    push_phase(0, 0, 1'b0);
    for (int a = 0; a < nb_ad; a++) begin
      push_wait(a, 1);
      push_phase(1, a, (a == nb_ad - 1));
    end
    for (int p = 0; p < nb_pt - 1; p++) begin
      push_wait(p, (p == 0) ? pt_wait0 : 1);
      push_phase(2, p, 1'b0);
    end
    push_wait(0, 1);
    push_phase(3, 0, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 0));
    exp_q.push_back('0);
  endtask

  // Pulse start (sampled at edge 0), then compare one vector per cycle.
  // data_valid is low for cycles lo_from..lo_to (sampled at their ending edge).
  task automatic run_op(input bit sel, input int max_cycles,
                        input int lo_from, input int lo_to);
    int cyc;
    logic [W-1:0] o, e;
    ciph_cnt = 0; tag_cnt = 0; im_cnt = 0; lsb_cnt = 0; done_cnt = 0;
    done_cyc = -1; lsb_cyc = -1; im_cyc = -1;
    cyc = 0;
    if (sel) begin start2 = 1'b1; dv2 = 1'b1; end
    else     begin start1 = 1'b1; dv1 = 1'b1; end
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      start1 = 1'b0;
      start2 = 1'b0;
      o = sel ? obs2 : obs1;
      e = exp_q.pop_front();
      check($sformatf("vec_c%0d", cyc), 32'(o), 32'(e));
      if (o[4])  ciph_cnt++;
      if (o[3])  tag_cnt++;
      if (o[14]) begin im_cnt++; im_cyc = cyc; end
      if (o[5])  begin lsb_cnt++; lsb_cyc = cyc; end
      if (o[15]) begin done_cnt++; done_cyc = cyc; end
      if (sel) dv2 = !(cyc >= lo_from && cyc <= lo_to);
      else     dv1 = !(cyc >= lo_from && cyc <= lo_to);
    end
  endtask

  initial begin
    rst1_n = 1'b0; start1 = 1'b0; dv1 = 1'b0;
    rst2_n = 1'b0; start2 = 1'b0; dv2 = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
    abort1 = 1'b0;
`endif

    // 1. Reset held while start toggles: everything stays 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start1 = $urandom_range(0, 1);
      start2 = ~start1;
      dv1 = $urandom_range(0, 1);
      check("reset_outputs", 32'(obs1), 32'd0);
      check("reset_busy", 32'(busy2), 32'd0);
    end
    start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(obs1), 32'd0);

    // 2. Default flow, data_valid held high.
    build_seq(1, 4, 1);
    run_op(1'b0, 70, 0, 0);
    check("flow_queue_drained", 32'(exp_q.size()), 32'd0);
    check("flow_done_cycle", 32'(done_cyc), 32'd54);
    check("flow_input_mode_cnt", 32'(im_cnt), 32'd1);
    check("flow_input_mode_cyc", 32'(im_cyc), 32'd1);
    check("flow_cipher_cnt", 32'(ciph_cnt), 32'd4);
    check("flow_tag_cnt", 32'(tag_cnt), 32'd1);
    check("flow_done_cnt", 32'(done_cnt), 32'd1);

    // 3. data_valid low for five cycles in the first PT_WAIT (cycles 20-24).
    @(negedge clk);
    exp_q.delete();
    build_seq(1, 4, 6);
    run_op(1'b0, 80, 20, 24);
    check("stall_queue_drained", 32'(exp_q.size()), 32'd0);
    check("stall_done_cycle", 32'(done_cyc), 32'd59);

    // 4. Two AD blocks, one PT block: AD goes straight to FINAL_WAIT.
    @(negedge clk);
    exp_q.delete();
    build_seq(2, 1, 1);
    run_op(1'b1, 60, 0, 0);
    check("ad2_queue_drained", 32'(exp_q.size()), 32'd0);
    check("ad2_lsb_cnt", 32'(lsb_cnt), 32'd1);
    check("ad2_lsb_cycle", 32'(lsb_cyc), 32'd26);
    check("ad2_cipher_cnt", 32'(ciph_cnt), 32'd1);
    check("ad2_done_cycle", 32'(done_cyc), 32'd40);

    // 5. Asynchronous reset during AD round 8 (cycle 16), then a clean rerun.
    @(negedge clk);
    exp_q.delete();
    build_seq(1, 4, 1);
    run_op(1'b0, 16, 0, 0);
    check("pre_reset_round", 32'(round1), 32'd8);
    exp_q.delete();
    #2 rst1_n = 1'b0;
    #1 check("async_reset_outputs", 32'(obs1), 32'd0);
    @(negedge clk);
    check("held_reset_outputs", 32'(obs1), 32'd0);
    rst1_n = 1'b1;
    @(negedge clk);
    build_seq(1, 4, 1);
    run_op(1'b0, 70, 0, 0);
    check("rerun_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rerun_done_cycle", 32'(done_cyc), 32'd54);

`ifdef ASCON_CTRL_ABORT_EN
    // 6. Abort at FINAL round 3 (cycle 45): IDLE next edge, no tag, no done.
    @(negedge clk);
    exp_q.delete();
    build_seq(1, 4, 1);
    run_op(1'b0, 45, 0, 0);
    check("pre_abort_round", 32'(round1), 32'd3);
    exp_q.delete();
    abort1 = 1'b1;
    dv1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("abort_idle", 32'(obs1), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_stays_idle", 32'(obs1), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
